// File: rtl/debounce_scheduler.sv
// debounce_scheduler
//   Shares one debounce timer among N noisy inputs. A round-robin scheduler
//   grants the timer to one input whose sampled level differs from its
//   debounced level. The new level is committed once the input has held it
//   for FINAL_VALUE+1 consecutive cycles while granted.
//
//   Optional build macro: SYNC_2FF_EN -- when defined, each noisy bit passes
//   through a two-flop synchronizer (one extra cycle of latency); otherwise a
//   single register stage samples noisy.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   noisy      in   [N-1:0] raw bouncing inputs, asynchronous to clk
//   debounced  out  [N-1:0] debounced levels
//   rise       out  [N-1:0] one-cycle pulse on debounced 0->1
//   fall       out  [N-1:0] one-cycle pulse on debounced 1->0
//   busy       out  timer granted (state != IDLE)
//   grant_idx  out  [$clog2(N)-1:0] index owning the timer, valid while busy
module debounce_scheduler #(
  parameter int N           = 4,
  parameter int FINAL_VALUE = 1_999_999,
  localparam int GW = $clog2(N),
  localparam int CW = ($clog2(FINAL_VALUE + 1) < 1) ? 1 : $clog2(FINAL_VALUE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  noisy,
  output logic [N-1:0]  debounced,
  output logic [N-1:0]  rise,
  output logic [N-1:0]  fall,
  output logic          busy,
  output logic [GW-1:0] grant_idx
);

  typedef enum logic [1:0] {IDLE, TIMING, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  s_q;
  logic [N-1:0]  deb_q, deb_d;
  logic [N-1:0]  rise_q, rise_d;
  logic [N-1:0]  fall_q, fall_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [CW-1:0] count_q, count_d;

  logic [N-1:0]  mismatch;
  logic          any_mismatch;
  logic [GW-1:0] pick;
  logic [GW-1:0] rr_after_grant;
  logic          window_done;

  // Input stage
`ifdef SYNC_2FF_EN
  logic [N-1:0] meta_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      s_q    <= '0;
    end else begin
      meta_q <= noisy;
      s_q    <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_q <= '0;
    else       s_q <= noisy;
  end
`endif

  assign mismatch       = s_q ^ deb_q;
  assign any_mismatch   = |mismatch;
  assign window_done    = (count_q == CW'(FINAL_VALUE));
  assign rr_after_grant = (grant_q == GW'(N - 1)) ? '0 : grant_q + 1'b1;

  // First mismatching index scanning rr_q, rr_q+1, ... modulo N.
  always_comb begin
    logic          found;
    int unsigned   idx;
    logic [GW-1:0] idx_g;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_g = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx   = (int'(rr_q) + i) % N;
      idx_g = GW'(idx);
      if (!found && mismatch[idx_g]) begin
        found = 1'b1;
        pick  = idx_g;
      end
    end
  end

  // State register and datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      deb_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_mismatch) state_d = TIMING;
      TIMING: begin
        if (!mismatch[grant_q])  state_d = IDLE;
        else if (window_done)    state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates; rise/fall are registered alongside debounced so the
  // pulse coincides exactly with the level change.
  always_comb begin
    deb_d   = deb_q;
    rise_d  = '0;
    fall_d  = '0;
    grant_d = grant_q;
    rr_d    = rr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (any_mismatch) begin
          grant_d = pick;
          count_d = '0;
        end
      end
      TIMING: begin
        if (!mismatch[grant_q])  rr_d    = rr_after_grant;
        else if (!window_done)   count_d = count_q + 1'b1;
      end
      COMMIT: begin
        deb_d[grant_q] = ~deb_q[grant_q];
        if (deb_q[grant_q]) fall_d[grant_q] = 1'b1;
        else                rise_d[grant_q] = 1'b1;
        rr_d = rr_after_grant;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != IDLE);
    grant_idx = grant_q;
    debounced = deb_q;
    rise      = rise_q;
    fall      = fall_q;
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed testbench for debounce_scheduler (N=4, FINAL_VALUE=9).
module tb_debounce_scheduler;

  localparam int N  = 4;
  localparam int FV = 9;
`ifdef SYNC_2FF_EN
  localparam int LAT = FV + 5;
`else
  localparam int LAT = FV + 4;
`endif
  // edge index (after first sampling edge) at which busy first goes high
  localparam int BS = LAT - FV - 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] noisy;
  logic [N-1:0] debounced, rise, fall;
  logic         busy;
  logic [1:0]   grant_idx;

  int total = 0;
  int bad   = 0;
  int r_a, r_b, n_a, n_b;

  always #5 clk = ~clk;

  debounce_scheduler #(.N(N), .FINAL_VALUE(FV)) dut (
    .clk       (clk),
    .reset     (reset),
    .noisy     (noisy),
    .debounced (debounced),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    noisy = '0;
    tick();
    tick();
    chk("rst_deb",   debounced, 0);
    chk("rst_rise",  rise,      0);
    chk("rst_fall",  fall,      0);
    chk("rst_busy",  busy,      0);
    chk("rst_grant", grant_idx, 0);
    reset = 1'b0;
    tick();

    // Single uncontended rise on index 2
    noisy = 4'b0100;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      chk("A_deb",  debounced, (k >= LAT) ? 4'b0100 : 4'b0000);
      chk("A_rise", rise,      (k == LAT) ? 4'b0100 : 4'b0000);
      chk("A_fall", fall,      0);
      chk("A_busy", busy,      (k >= BS && k < LAT) ? 1 : 0);
      if (k >= BS && k < LAT) chk("A_grant", grant_idx, 2);
    end

    // Release of index 2
    noisy = 4'b0000;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      chk("B_deb",  debounced, (k >= LAT) ? 4'b0000 : 4'b0100);
      chk("B_fall", fall,      (k == LAT) ? 4'b0100 : 4'b0000);
      chk("B_rise", rise,      0);
    end

    // Bounce on index 0: 1,0,1 with 3-cycle gaps, then held
    n_a = 0;
    noisy = 4'b0001;
    for (int k = 0; k < 3; k++) begin tick(); if (rise[0]) n_a++; end
    noisy = 4'b0000;
    for (int k = 0; k < 3; k++) begin tick(); if (rise[0]) n_a++; end
    chk("C_early_deb",  debounced, 0);
    chk("C_early_rise", n_a,       0);
    noisy = 4'b0001;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      if (rise[0]) n_a++;
      chk("C_fall", fall, 0);
    end
    chk("C_rises", n_a,       1);
    chk("C_deb",   debounced, 4'b0001);

    // Contention: indices 1 and 3 together, rr_ptr=0 after reset
    noisy = '0;
    do_reset();
    r_a = -1; r_b = -1; n_a = 0; n_b = 0;
    noisy = 4'b1010;
    for (int k = 1; k <= LAT + FV + 6; k++) begin
      tick();
      if (rise[1]) begin n_a++; if (r_a < 0) r_a = k; end
      if (rise[3]) begin n_b++; if (r_b < 0) r_b = k; end
      if (k == BS)      chk("D_grant1", grant_idx, 1);
      if (k == LAT)     chk("D_idle",   busy,      0);
      if (k == LAT + 1) begin
        chk("D_busy3",  busy,      1);
        chk("D_grant3", grant_idx, 3);
      end
    end
    chk("D_t1",  r_a, LAT);
    chk("D_t3",  r_b, LAT + FV + 3);
    chk("D_n1",  n_a, 1);
    chk("D_n3",  n_b, 1);
    chk("D_deb", debounced, 4'b1010);

    // Fairness: rr_ptr wrapped to 0; mismatch on 0 (rise) and 3 (fall)
    r_a = -1; r_b = -1;
    noisy = 4'b0011;
    for (int k = 1; k <= LAT + FV + 6; k++) begin
      tick();
      if (rise[0] && r_a < 0) r_a = k;
      if (fall[3] && r_b < 0) r_b = k;
      if (k == BS) chk("E_grant0", grant_idx, 0);
    end
    chk("E_t0",  r_a, LAT);
    chk("E_t3",  r_b, LAT + FV + 3);
    chk("E_deb", debounced, 4'b0011);

    // Reset asserted mid-window on index 2
    noisy = '0;
    do_reset();
    noisy = 4'b0100;
    for (int k = 0; k < 5; k++) tick();
    chk("F_busy_pre",  busy,      1);
    chk("F_grant_pre", grant_idx, 2);
    reset = 1'b1;
    #1;
    chk("F_deb",   debounced, 0);
    chk("F_rise",  rise,      0);
    chk("F_fall",  fall,      0);
    chk("F_busy",  busy,      0);
    chk("F_grant", grant_idx, 0);
    tick();
    tick();
    reset = 1'b0;
    r_a = -1; n_a = 0;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      if (rise[2]) begin n_a++; if (r_a < 0) r_a = k; end
    end
    chk("F_n2",      n_a,       1);
    chk("F_t2",      r_a,       LAT);
    chk("F_deb_end", debounced, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
# debounce_scheduler

Shares one debounce timer among N noisy inputs (push-buttons, switches) instead of instantiating one timer per input. A round-robin scheduler grants the timer to one input whose synchronized level differs from its debounced level; the debounced level is committed only after the input stays stable for FINAL_VALUE+1 cycles. It sits between the board I/O pins and the user FSMs, which consume `debounced` levels and the one-cycle `rise`/`fall` event pulses.

## Interface
- N, 4: number of inputs; legal range 2..16.
- FINAL_VALUE, 1_999_999: terminal count of the shared timer; the stable window is FINAL_VALUE+1 cycles (20 ms at 100 MHz). Counter width is $clog2(FINAL_VALUE+1).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- noisy  in  N  raw bouncing inputs; asynchronous to clk.
- debounced  out  N  debounced levels.
- rise  out  N  one-cycle pulse when debounced[i] goes 0→1.
- fall  out  N  one-cycle pulse when debounced[i] goes 1→0.
- busy  out  1  high while the timer is granted (state ≠ IDLE).
- grant_idx  out  $clog2(N)  index currently owning the timer; valid only while busy.

## Operation
- Input stage: s = registered noisy (see Configuration). mismatch[i] = s[i] ^ debounced[i].
- rr_ptr ($clog2(N) bits) holds the highest-priority index for the next grant.
- FSM states IDLE, TIMING, COMMIT:
  - IDLE: if any mismatch, grant g = first mismatching index scanning rr_ptr, rr_ptr+1, … mod N; load grant_idx=g, count=0; go TIMING. Otherwise stay.
  - TIMING: if mismatch[g]==0 (bounced back), abort: rr_ptr=(g+1) mod N, go IDLE, no output change. Else if count==FINAL_VALUE, go COMMIT. Else count=count+1.
  - COMMIT: debounced[g] toggles; rise[g] or fall[g] pulses for exactly that update cycle; rr_ptr=(g+1) mod N; go IDLE.
- Only the granted input can change; other mismatching inputs wait. Round-robin guarantees any input stable long enough is served within N grants.
- Counter saturates by construction (never exceeds FINAL_VALUE); no wrap.
- Changes on non-granted inputs during TIMING do not affect the running window.
- rise/fall are never both high for the same index; at most one bit of rise|fall is high per cycle.

## Timing
- Reset values: debounced=0, rise=0, fall=0, busy=0, grant_idx=0, rr_ptr=0, count=0, input-stage flops=0, state=IDLE.
- Reset mid-TIMING discards the window; no pulse is produced.
- Inputs high at reset release are debounced to 1 through the normal path and produce a rise pulse.
- Uncontended latency, from the first clk edge sampling a new stable level to the edge at which debounced/rise/fall change: FINAL_VALUE+5 edges with SYNC_2FF_EN, FINAL_VALUE+4 without.
- IDLE→TIMING consumes one cycle; COMMIT→IDLE one cycle; back-to-back grants are therefore separated by at least one IDLE cycle.
- busy rises on the edge entering TIMING and falls on the edge leaving COMMIT or the abort edge.

## Configuration
- SYNC_2FF_EN defined: each noisy bit passes through a two-flop synchronizer before s; latency as above.
- SYNC_2FF_EN undefined: single register stage on noisy; one cycle less latency; used only for simulation or pre-synchronized sources.

## Test plan
- FINAL_VALUE=9, N=4, SYNC_2FF_EN: noisy[2] 0→1 held → debounced[2]=1 and rise[2] one-cycle pulse exactly 14 edges after first sampling edge; busy high 11 cycles, grant_idx=2.
- Bounce: noisy[0] toggles 1,0,1 with 3-cycle gaps then holds 1 → aborts with no output change; final debounced[0]=1 with a single rise pulse.
- Contention: noisy[1] and noisy[3] rise same cycle, rr_ptr=0 → index 1 committed first, index 3 granted after one IDLE cycle; both rise pulses, 1 before 3.
- Fairness: after committing index 3, rr_ptr wraps to 0; simultaneous mismatch on 0 and 3 → 0 granted first.
- Reset asserted mid-TIMING for index 2 → all outputs 0 immediately; after release with noisy[2]=1 held, full window restarts and rise[2] pulses once.
- Release: noisy[2] 1→0 held after debounced[2]=1 → fall[2] pulse after FINAL_VALUE+5 edges, rise never asserted.
